// File: rtl/ycc2rgb.sv
// ycc2rgb: inverse colour-space converter. It takes signed fixed-point Y/Cb/Cr
// pixels and produces packed 8-bit RGB. The pipeline is four register stages
// deep, accepts one pixel per clock and has no backpressure. A pixel counter
// pulses oDone with the last pixel of each frame.
//
// Ports
//   clk     in   1   clock, rising edge
//   reset   in   1   synchronous, active-high
//   iValid  in   1   iY/iCb/iCr hold a pixel this cycle
//   iY      in   18  signed, 9 int / 9 frac
//   iCb     in   18  signed, 9 int / 9 frac, zero-centred
//   iCr     in   18  signed, 9 int / 9 frac, zero-centred
//   oData   out  24  {R,G,B}, 8 bits each, unsigned
//   oValid  out  1   oData holds a pixel this cycle
//   oDone   out  1   one-cycle pulse with the last pixel of a frame
module ycc2rgb #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  // Row-major {R;G;B} x {Y,Cb,Cr}, 16 fractional bits. The first entry is the MSB slice.
  parameter logic [9*18-1:0] COEF = {
    18'sd65536,  18'sd0,      18'sd91881,
    18'sd65536, -18'sd22554, -18'sd46802,
    18'sd65536,  18'sd116130, 18'sd0
  }
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iValid,
  input  logic signed [17:0] iY,
  input  logic signed [17:0] iCb,
  input  logic signed [17:0] iCr,
  output logic [23:0]        oData,
  output logic               oValid,
  output logic               oDone
);

  localparam int FRAME_PIXELS = WIDTH * HEIGHT;
  localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  // Coefficient k = row*3 + col. Entry 0 sits in the top slice of COEF.
  function automatic logic signed [17:0] coef(input int k);
    return COEF[(8 - k) * 18 +: 18];
  endfunction

  // Data path registers. These have no reset because the valid bits alone
  // decide what is emitted.
  logic signed [17:0] pix_d  [3];
  logic signed [17:0] pix_q  [3];
  logic signed [35:0] prod_d [9];
  logic signed [35:0] prod_q [9];
  logic signed [37:0] sum_d  [3];
  logic signed [37:0] sum_q  [3];

  // Control registers. These are reset.
  logic             v1_q, v2_q, v3_q;
  logic [23:0]      out_data_d, out_data_q;
  logic             out_valid_d, out_valid_q;
  logic             out_done_d, out_done_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // S1: capture the pixel only when it is valid. This keeps don't-care or X
  // data on idle cycles out of the arithmetic.
  always_comb begin
    for (int k = 0; k < 3; k++) pix_d[k] = pix_q[k];
    if (iValid) begin
      pix_d[0] = iY;
      pix_d[1] = iCb;
      pix_d[2] = iCr;
    end
  end

  // S2: nine full-precision signed products (25 fractional bits).
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = 36'(pix_q[k % 3]) * 36'(coef(k));
    end
  end

  // S3: one row sum per output channel, widened so that three terms cannot overflow.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      sum_d[r] = 38'(prod_q[3*r]) + 38'(prod_q[3*r + 1]) + 38'(prod_q[3*r + 2]);
    end
  end

  // S4: round half up, drop the 25 fractional bits, then saturate to 0..255.
  // oData holds its value through bubbles.
  always_comb begin
    logic signed [37:0] s;
    logic signed [37:0] sh;
    logic [7:0]         chan;
    s          = '0;
    sh         = '0;
    chan       = '0;
    out_data_d = out_data_q;
    if (v3_q) begin
      for (int r = 0; r < 3; r++) begin
        s  = sum_q[r] + 38'sd16777216;
        sh = s >>> 25;
        if (sh < 0)              chan = 8'd0;
        else if (sh > 38'sd255)  chan = 8'd255;
        else                     chan = sh[7:0];
        out_data_d[23 - 8*r -: 8] = chan;
      end
    end
  end

  // Frame pixel counter. It wraps on the last pixel so that the next frame
  // can follow without a gap.
  always_comb begin
    out_valid_d = v3_q;
    out_done_d  = 1'b0;
    cnt_d       = cnt_q;
    if (v3_q) begin
      if (cnt_q == LAST_PIX) begin
        out_done_d = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    pix_q  <= pix_d;
    prod_q <= prod_d;
    sum_q  <= sum_d;
  end

  // Clearing every valid bit discards in-flight pixels on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_done_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      v1_q        <= iValid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_done_q  <= out_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign oData  = out_data_q;
  assign oValid = out_valid_q;
  assign oDone  = out_done_q;

endmodule

// File: tb/tb_ycc2rgb.sv
// tb_ycc2rgb: self-checking bench for ycc2rgb, built with a 4x2 frame.
// Each driven pixel pushes its expected output and expected cycle into exp_q.
// A monitor records every cycle that shows oValid or oDone, and every change
// of oData, into obs_q. Each test task then pops both queues and compares them.
module tb_ycc2rgb;

  localparam int W = 4;
  localparam int H = 2;
  localparam int FRAME = W * H;

  logic               clk;
  logic               reset;
  logic               iValid;
  logic signed [17:0] iY, iCb, iCr;
  logic [23:0]        oData;
  logic               oValid;
  logic               oDone;

  ycc2rgb #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .iValid(iValid),
    .iY(iY), .iCb(iCb), .iCr(iCr),
    .oData(oData), .oValid(oValid), .oDone(oDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cyc; logic [23:0] data; logic done; } exp_t;
  typedef struct { int cyc; logic valid; logic [23:0] data; logic done; } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   cyc = 0;
  int   mdl_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [23:0] last_data = 24'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor. Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    obs_t o;
    if (reset) begin
      last_data = 24'h0;
    end else if (oValid || oDone || oData !== last_data) begin
      o.cyc = cyc; o.valid = oValid; o.data = oData; o.done = oDone;
      obs_q.push_back(o);
      last_data = oData;
    end
  end

  // Reference arithmetic from the coefficient table. Rounding is half up,
  // using a floor shift of 25 bits, and the result is clamped to 0..255.
  function automatic logic [7:0] sat(input longint s);
    longint v;
    v = (s + 64'sd16777216) >>> 25;
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic logic [23:0] model(input logic signed [17:0] y, cb, cr);
    longint ly, lcb, lcr;
    ly = y; lcb = cb; lcr = cr;
    return {sat(65536*ly + 91881*lcr),
            sat(65536*ly - 22554*lcb - 46802*lcr),
            sat(65536*ly + 116130*lcb)};
  endfunction

  function automatic logic signed [17:0] to_fix(input real x);
    real t;
    int  i;
    t = x * 512.0;
    if (t >= 0.0) i = $rtoi(t + 0.5);
    else          i = -$rtoi(-t + 0.5);
    return 18'(i);
  endfunction

  // Stimulus helpers. These only drive the inputs and push expected results.
  task automatic drive_pixel(input logic signed [17:0] y, cb, cr,
                             input logic [23:0] want, input bit push);
    exp_t e;
    @(posedge clk); #1;
    iValid = 1'b1; iY = y; iCb = cb; iCr = cr;
    if (push) begin
      e.cyc  = cyc + 4;
      e.data = want;
      e.done = (mdl_cnt == FRAME - 1);
      mdl_cnt = e.done ? 0 : mdl_cnt + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic bubble(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      iValid = 1'b0;
      iY = 18'($urandom); iCb = 18'($urandom); iCr = 18'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1; iValid = 1'b0;
    repeat (n - 1) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_cnt = 0;
  endtask

  task automatic rand_pixel(output logic signed [17:0] y, cb, cr);
    y  = 18'($urandom_range(0, 131071));
    cb = 18'(int'($urandom_range(0, 131071)) - 65536);
    cr = 18'(int'($urandom_range(0, 131071)) - 65536);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (oData !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h, expected 000000", oData); end
    n_checks++;
    if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", oValid); end
    n_checks++;
    if (oDone !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, expected 0", oDone); end
    reset = 1'b0;
    bubble(8);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL reset_idle: %0d output events while idle, expected 0", obs_q.size());
      obs_q.delete();
    end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    exp_t e; obs_t o;
    drive_pixel(18'sd65536, 18'sd0, 18'sd0, 24'h808080, 1'b1);
    bubble(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL single: no output, expected %h at cycle %0d", e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.valid !== 1'b1 || o.data !== e.data || o.done !== e.done || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL single: got v=%b d=%h done=%b cyc=%0d, expected v=1 d=%h done=%b cyc=%0d",
                   o.valid, o.data, o.done, o.cyc, e.data, e.done, e.cyc);
        end else $display("single: pixel %h ok at cycle %0d", o.data, o.cyc);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL single_extra: %0d extra output events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_known();
    exp_t e; obs_t o;
    drive_pixel(18'sd51200, 18'sd0, 18'sd25600, 24'hAA4064, 1'b1);
    // The G value is 250 - 0.344*100 - 0.714*100 = 144.2, which rounds to 144.
    drive_pixel(18'sd128000, 18'sd51200, 18'sd51200, 24'hFF90FF, 1'b1);
    drive_pixel(18'sd0, -18'sd51200, -18'sd51200, 24'h006A00, 1'b1);
    bubble(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL known: no output, expected %h at cycle %0d", e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.valid !== 1'b1 || o.data !== e.data || o.done !== e.done || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL known: got v=%b d=%h done=%b cyc=%0d, expected v=1 d=%h done=%b cyc=%0d",
                   o.valid, o.data, o.done, o.cyc, e.data, e.done, e.cyc);
        end else $display("known: pixel %h ok at cycle %0d", o.data, o.cyc);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL known_extra: %0d extra output events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_stream();
    exp_t e; obs_t o;
    logic signed [17:0] y, cb, cr;
    for (int i = 0; i < 20; i++) begin
      rand_pixel(y, cb, cr);
      drive_pixel(y, cb, cr, model(y, cb, cr), 1'b1);
      bubble($urandom_range(1, 3));
    end
    bubble(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL stream: no output, expected %h at cycle %0d", e.data, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o.valid !== 1'b1 || o.data !== e.data || o.done !== e.done || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL stream: got v=%b d=%h done=%b cyc=%0d, expected v=1 d=%h done=%b cyc=%0d",
                   o.valid, o.data, o.done, o.cyc, e.data, e.done, e.cyc);
        end else $display("stream: pixel %h done=%b ok at cycle %0d", o.data, o.done, o.cyc);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL stream_extra: %0d extra output events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_frame_done();
    exp_t e; obs_t o;
    logic signed [17:0] y, cb, cr;
    do_reset(2);
    for (int i = 0; i < FRAME; i++) begin
      rand_pixel(y, cb, cr);
      drive_pixel(y, cb, cr, model(y, cb, cr), 1'b1);
      bubble($urandom_range(1, 2));
    end
    // The second frame follows with no gap between pixels.
    for (int i = 0; i < FRAME; i++) begin
      rand_pixel(y, cb, cr);
      drive_pixel(y, cb, cr, model(y, cb, cr), 1'b1);
    end
    bubble(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL frame: no output, expected %h done=%b", e.data, e.done);
      end else begin
        o = obs_q.pop_front();
        if (o.valid !== 1'b1 || o.data !== e.data || o.done !== e.done || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL frame: got v=%b d=%h done=%b cyc=%0d, expected v=1 d=%h done=%b cyc=%0d",
                   o.valid, o.data, o.done, o.cyc, e.data, e.done, e.cyc);
        end else $display("frame: pixel %h done=%b ok at cycle %0d", o.data, o.done, o.cyc);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL frame_extra: %0d extra output events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e; obs_t o;
    logic signed [17:0] y, cb, cr;
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      rand_pixel(y, cb, cr);
      drive_pixel(y, cb, cr, model(y, cb, cr), 1'b1);
    end
    bubble(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL midreset_pre: no output, expected %h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.valid !== 1'b1 || o.data !== e.data || o.done !== e.done || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL midreset_pre: got v=%b d=%h done=%b cyc=%0d, expected v=1 d=%h done=%b cyc=%0d",
                   o.valid, o.data, o.done, o.cyc, e.data, e.done, e.cyc);
        end else $display("midreset_pre: pixel %h ok at cycle %0d", o.data, o.cyc);
      end
    end
    // Three pixels are in flight when a one-cycle reset hits. None of them may appear.
    for (int i = 0; i < 3; i++) begin
      rand_pixel(y, cb, cr);
      drive_pixel(y, cb, cr, 24'h0, 1'b0);
    end
    do_reset(1);
    bubble(8);
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_flush: %0d output events after reset, expected 0", obs_q.size());
      obs_q.delete();
    end else $display("midreset_flush: in-flight pixels discarded");
    for (int i = 0; i < FRAME; i++) begin
      rand_pixel(y, cb, cr);
      drive_pixel(y, cb, cr, model(y, cb, cr), 1'b1);
      if (i % 3 == 1) bubble(1);
    end
    bubble(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL midreset_post: no output, expected %h done=%b", e.data, e.done);
      end else begin
        o = obs_q.pop_front();
        if (o.valid !== 1'b1 || o.data !== e.data || o.done !== e.done || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL midreset_post: got v=%b d=%h done=%b cyc=%0d, expected v=1 d=%h done=%b cyc=%0d",
                   o.valid, o.data, o.done, o.cyc, e.data, e.done, e.cyc);
        end else $display("midreset_post: pixel %h done=%b ok at cycle %0d", o.data, o.done, o.cyc);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_extra: %0d extra output events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_round_trip();
    exp_t e; obs_t o;
    real r, g, b;
    int  diff, got, want;
    bit  bad;
    for (int k = 0; k < 8; k++) begin
      r = (k & 4) ? 255.0 : 0.0;
      g = (k & 2) ? 255.0 : 0.0;
      b = (k & 1) ? 255.0 : 0.0;
      drive_pixel(to_fix( 0.299    * r + 0.587    * g + 0.114    * b),
                  to_fix(-0.168736 * r - 0.331264 * g + 0.5      * b),
                  to_fix( 0.5      * r - 0.418688 * g - 0.081312 * b),
                  {(k & 4) ? 8'hFF : 8'h00, (k & 2) ? 8'hFF : 8'h00, (k & 1) ? 8'hFF : 8'h00}, 1'b1);
    end
    bubble(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL roundtrip: no output, expected about %h", e.data);
      end else begin
        o = obs_q.pop_front();
        bad = (o.valid !== 1'b1) || (o.done !== e.done) || (o.cyc != e.cyc);
        for (int c = 0; c < 3; c++) begin
          got  = int'(o.data[23 - 8*c -: 8]);
          want = int'(e.data[23 - 8*c -: 8]);
          diff = (got > want) ? got - want : want - got;
          if (diff > 1) bad = 1'b1;
        end
        if (bad) begin
          n_fail++;
          $display("FAIL roundtrip: got v=%b d=%h done=%b cyc=%0d, expected v=1 d=%h(+/-1) done=%b cyc=%0d",
                   o.valid, o.data, o.done, o.cyc, e.data, e.done, e.cyc);
        end else $display("roundtrip: corner %h -> %h ok", e.data, o.data);
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL roundtrip_extra: %0d extra output events, expected 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; iValid = 1'b0; iY = '0; iCb = '0; iCr = '0;
    test_reset();
    test_single();
    test_known();
    test_stream();
    test_frame_done();
    test_reset_mid_frame();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
